wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: PEND cycles before the buffered load result forces priority (legal range 2..15).
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 alu_valid_i  in  1  single-cycle ALU writeback request; has no backpressure.
REQ-005 alu_waddr_i  in  5  ALU destination register.
REQ-006 alu_wdata_i  in  32  ALU result.
REQ-007 mem_valid_i  in  1  load-unit writeback request (valid/ready).
REQ-008 mem_ready_o  out  1  load request accepted when mem_valid_i & mem_ready_o.
REQ-009 mem_waddr_i  in  5  load destination register.
REQ-010 mem_wdata_i  in  32  load data.
REQ-011 reg_wen_o  out  1  register-file write enable.
REQ-012 reg_waddr_o  out  5  register-file write address.
REQ-013 reg_wdata_o  out  32  register-file write data.
REQ-014 iss_mark_i  in  1  a load with destination iss_rd_i is issued this cycle.
REQ-015 iss_rd_i  in  5  issuing instruction destination.
REQ-016 iss_rs1_i / iss_rs2_i  in  5 each  issuing instruction sources.
REQ-017 stall_o  out  1  issue must hold (hazard or forced drain).
REQ-018 err_o  out  1  sticky: ALU write arrived while in FORCE.

Function
REQ-019 Write-port outputs are registered: an accepted request appears on reg_* exactly 1 cycle later, for exactly 1 cycle.
REQ-020 Requests with address 0 are accepted but produce reg_wen_o=0.
REQ-021 States: EMPTY, PEND, FORCE; buffer = one 37-bit entry (addr + data) plus wait counter.
REQ-022 EMPTY: mem_ready_o=1; ALU only -> ALU written; mem only -> mem written; both -> ALU written, mem captured into buffer, counter=0, next PEND.
REQ-023 PEND: mem_ready_o=0; alu_valid_i=0 -> buffer written, next EMPTY; alu_valid_i=1 -> ALU written, counter+1; counter reaching STARVE_LIMIT-1 -> next FORCE.
REQ-024 FORCE: mem_ready_o=0, stall_o=1; alu_valid_i=0 -> buffer written, next EMPTY; alu_valid_i=1 -> ALU still wins, err_o set, remain FORCE.
REQ-025 The ALU is never dropped or delayed; at most one reg_wen_o per cycle.
REQ-026 Scoreboard: 32 pending bits; iss_mark_i sets bit iss_rd_i (x0 never set); a load write reaching reg_* clears its bit.
REQ-027 Set and clear of the same bit in one cycle: set wins.
REQ-028 stall_o = pending[iss_rs1_i] | pending[iss_rs2_i] | pending[iss_rd_i] | (state==FORCE), combinational; x0 lookups read 0.
REQ-029 Load data is never reordered: at most one load result in flight through the buffer.

Reset
REQ-030 rst high at a clock edge: state=EMPTY, buffer invalid, counter=0, pending=0, err_o=0, reg_wen_o=0, reg_waddr_o=0, reg_wdata_o=0.
REQ-031 mem_ready_o=1 and stall_o=0 in the cycle after reset.
REQ-032 Reset mid-operation discards the buffered load and all pending bits; no write is emitted for it.

Structure
REQ-033 XLEN=32, REG_ADDR_W=5 and the state encoding (EMPTY, PEND, FORCE) live in the shared package rv_pkg.
REQ-034 Pending bits, set/clear logic and stall lookup form one sub-module, wb_scoreboard; arbitration FSM and buffer stay in wb_arbiter.

Verification
REQ-035 ALU x5=0x11 alone -> next cycle reg_wen_o=1, waddr=5, wdata=0x11.
REQ-036 ALU x3=0xA and mem x7=0xB same cycle -> cycle+1 writes x3; mem_ready_o=0; ALU idle at cycle+1 -> cycle+2 writes x7, mem_ready_o=1.
REQ-037 STARVE_LIMIT=4, buffered load with ALU valid every cycle -> FORCE, stall_o=1 after 3 PEND cycles; first ALU-idle cycle drains buffer; ALU during FORCE -> err_o=1.
REQ-038 iss_mark_i rd=9, then issue rs1=9 -> stall_o=1 until load x9 written; clear and re-mark of x9 in same cycle -> bit stays set.
REQ-039 ALU x0=0xFF -> reg_wen_o stays 0; stall never raised for rs1=0.
REQ-040 rst while in PEND -> next cycle EMPTY, no write for the buffered load, pending=0, err_o=0.

Source files
------------

// File: rtl/rv_pkg.sv
// Shared register-file widths and writeback arbiter encodings.
// Pulled in by the arbiter and its scoreboard through import rv_pkg::*.
package rv_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned NUM_REGS   = 1 << REG_ADDR_W;

  typedef logic [1:0] arb_state_t;

  localparam arb_state_t StEmpty = 2'd0;
  localparam arb_state_t StPend  = 2'd1;
  localparam arb_state_t StForce = 2'd2;

  // One buffered load result: destination plus data (37 bits).
  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wb_entry_t;

  // x0 is hardwired to zero, so writes to it are never performed.
  function automatic logic writes_reg(input logic [REG_ADDR_W-1:0] addr);
    return addr != '0;
  endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register, set on load issue,
// cleared when the load result is written back; drives the issue stall.
module wb_scoreboard
  import rv_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en_i,
  input  logic [REG_ADDR_W-1:0] set_addr_i,
  input  logic                  clr_en_i,
  input  logic [REG_ADDR_W-1:0] clr_addr_i,
  input  logic [REG_ADDR_W-1:0] rs1_i,
  input  logic [REG_ADDR_W-1:0] rs2_i,
  input  logic [REG_ADDR_W-1:0] rd_i,
  input  logic                  force_i,
  output logic                  stall_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;
  logic [NUM_REGS-1:0] set_mask, clr_mask;

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    if (set_en_i && writes_reg(set_addr_i)) begin
      set_mask[set_addr_i] = 1'b1;
    end
    if (clr_en_i) begin
      clr_mask[clr_addr_i] = 1'b1;
    end
    // Set is applied after clear so a same-cycle re-mark keeps the bit.
    pend_d    = (pend_q & ~clr_mask) | set_mask;
    pend_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= '0;
    end else begin
      pend_q <= pend_d;
    end
  end

  // Bit 0 is never set, so x0 lookups always read 0.
  assign stall_o = pend_q[rs1_i] | pend_q[rs2_i] | pend_q[rd_i] | force_i;

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: the ALU always wins the single write port, a
// colliding load is parked in a one-entry buffer and forced out after STARVE_LIMIT cycles.
module wb_arbiter
  import rv_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  alu_valid_i,
  input  logic [REG_ADDR_W-1:0] alu_waddr_i,
  input  logic [XLEN-1:0]       alu_wdata_i,

  input  logic                  mem_valid_i,
  output logic                  mem_ready_o,
  input  logic [REG_ADDR_W-1:0] mem_waddr_i,
  input  logic [XLEN-1:0]       mem_wdata_i,

  output logic                  reg_wen_o,
  output logic [REG_ADDR_W-1:0] reg_waddr_o,
  output logic [XLEN-1:0]       reg_wdata_o,

  input  logic                  iss_mark_i,
  input  logic [REG_ADDR_W-1:0] iss_rd_i,
  input  logic [REG_ADDR_W-1:0] iss_rs1_i,
  input  logic [REG_ADDR_W-1:0] iss_rs2_i,
  output logic                  stall_o,

  output logic                  err_o
);

  localparam logic [3:0] CntLast = 4'(STARVE_LIMIT - 1);

  arb_state_t state_q, state_d;
  wb_entry_t  buf_q, buf_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] cnt_inc;
  logic       err_q, err_d;

  // Write selected this cycle; it lands on reg_* at the next edge.
  logic                  wr_en;
  logic [REG_ADDR_W-1:0] wr_addr;
  logic [XLEN-1:0]       wr_data;
  logic                  wr_is_mem;

  logic                  reg_wen_q;
  logic [REG_ADDR_W-1:0] reg_waddr_q;
  logic [XLEN-1:0]       reg_wdata_q;

  assign cnt_inc = cnt_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    err_d       = err_q;
    wr_en       = 1'b0;
    wr_addr     = '0;
    wr_data     = '0;
    wr_is_mem   = 1'b0;
    mem_ready_o = 1'b0;

    case (state_q)
      StEmpty: begin
        mem_ready_o = 1'b1;
        if (alu_valid_i) begin
          wr_en   = 1'b1;
          wr_addr = alu_waddr_i;
          wr_data = alu_wdata_i;
          if (mem_valid_i) begin
            buf_d.addr = mem_waddr_i;
            buf_d.data = mem_wdata_i;
            cnt_d      = '0;
            state_d    = StPend;
          end
        end else if (mem_valid_i) begin
          wr_en     = 1'b1;
          wr_addr   = mem_waddr_i;
          wr_data   = mem_wdata_i;
          wr_is_mem = 1'b1;
        end
      end

      StPend: begin
        if (alu_valid_i) begin
          wr_en   = 1'b1;
          wr_addr = alu_waddr_i;
          wr_data = alu_wdata_i;
          cnt_d   = cnt_inc;
          if (cnt_inc == CntLast) begin
            state_d = StForce;
          end
        end else begin
          wr_en     = 1'b1;
          wr_addr   = buf_q.addr;
          wr_data   = buf_q.data;
          wr_is_mem = 1'b1;
          state_d   = StEmpty;
        end
      end

      StForce: begin
        if (alu_valid_i) begin
          // The ALU has no backpressure, so it still wins; flag the starvation.
          wr_en   = 1'b1;
          wr_addr = alu_waddr_i;
          wr_data = alu_wdata_i;
          err_d   = 1'b1;
        end else begin
          wr_en     = 1'b1;
          wr_addr   = buf_q.addr;
          wr_data   = buf_q.data;
          wr_is_mem = 1'b1;
          state_d   = StEmpty;
        end
      end

      default: begin
        state_d = StEmpty;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StEmpty;
      buf_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      reg_wen_q   <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      reg_wen_q   <= wr_en & writes_reg(wr_addr);
      reg_waddr_q <= wr_addr;
      reg_wdata_q <= wr_data;
    end
  end

  assign reg_wen_o   = reg_wen_q;
  assign reg_waddr_o = reg_waddr_q;
  assign reg_wdata_o = reg_wdata_q;
  assign err_o       = err_q;

  wb_scoreboard u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .set_en_i   (iss_mark_i),
    .set_addr_i (iss_rd_i),
    .clr_en_i   (wr_en & wr_is_mem),
    .clr_addr_i (wr_addr),
    .rs1_i      (iss_rs1_i),
    .rs2_i      (iss_rs2_i),
    .rd_i       (iss_rd_i),
    .force_i    (state_q == StForce),
    .stall_o    (stall_o)
  );

endmodule
